// File: rtl/logic_eval_arbiter.sv
// Round-robin arbiter sharing one registered select-logic evaluator z = (b & c) | (a & ~b).
// Optional LOGIC_ARB_STATS_EN adds a 16-bit served_cnt output counting response handshakes.
module logic_eval_arbiter #(
  parameter int N = 4,
  parameter int W = 8,
  localparam int IW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic [N*W-1:0]  a_in,
  input  logic [N*W-1:0]  b_in,
  input  logic [N*W-1:0]  c_in,
  output logic [N-1:0]    gnt,
  output logic            rsp_valid,
  output logic [IW-1:0]   rsp_id,
  output logic [W-1:0]    rsp_z,
  input  logic            rsp_ready,
  output logic            busy
`ifdef LOGIC_ARB_STATS_EN
  ,
  output logic [15:0]     served_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         state_reg, state_next;
  logic [IW-1:0]  ptr_reg, ptr_next;
  logic [N-1:0]   gnt_reg, gnt_next;
  logic           valid_reg, valid_next;
  logic [IW-1:0]  id_reg, id_next;
  logic [W-1:0]   z_reg, z_next;
  logic [W-1:0]   a_reg, a_next;
  logic [W-1:0]   b_reg, b_next;
  logic [W-1:0]   c_reg, c_next;

  logic [W-1:0]   a_arr [N];
  logic [W-1:0]   b_arr [N];
  logic [W-1:0]   c_arr [N];

  logic           win_found;
  logic [IW-1:0]  win_idx;

  for (genvar gi = 0; gi < N; gi++) begin : g_unpack
    assign a_arr[gi] = a_in[gi*W +: W];
    assign b_arr[gi] = b_in[gi*W +: W];
    assign c_arr[gi] = c_in[gi*W +: W];
  end

  // Position k steps after base, modulo N (N need not be a power of two).
  function automatic logic [IW-1:0] rr_index(input logic [IW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= N) s = s - N;
    return IW'(s);
  endfunction

  // Scan starts just after the last served requester so it gets lowest priority.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 1; k <= N; k++) begin
      if (!win_found && req[rr_index(ptr_reg, k)]) begin
        win_found = 1'b1;
        win_idx   = rr_index(ptr_reg, k);
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    gnt_next   = gnt_reg;
    valid_next = valid_reg;
    id_next    = id_reg;
    z_next     = z_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    c_next     = c_reg;
    case (state_reg)
      IDLE: begin
        if (win_found) begin
          state_next = EVAL;
          id_next    = win_idx;
          gnt_next   = N'(1) << win_idx;
          a_next     = a_arr[win_idx];
          b_next     = b_arr[win_idx];
          c_next     = c_arr[win_idx];
        end
      end
      EVAL: begin
        state_next = RESP;
        gnt_next   = '0;
        valid_next = 1'b1;
        z_next     = (b_reg & c_reg) | (a_reg & ~b_reg);
      end
      RESP: begin
        if (rsp_ready) begin
          state_next = IDLE;
          valid_next = 1'b0;
          ptr_next   = id_reg;
        end
      end
      default: begin
        state_next = IDLE;
        gnt_next   = '0;
        valid_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      ptr_reg   <= IW'(N - 1);
      gnt_reg   <= '0;
      valid_reg <= 1'b0;
      id_reg    <= '0;
      z_reg     <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      c_reg     <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      gnt_reg   <= gnt_next;
      valid_reg <= valid_next;
      id_reg    <= id_next;
      z_reg     <= z_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      c_reg     <= c_next;
    end
  end

  assign gnt       = gnt_reg;
  assign rsp_valid = valid_reg;
  assign rsp_id    = id_reg;
  assign rsp_z     = z_reg;
  assign busy      = (state_reg != IDLE);

`ifdef LOGIC_ARB_STATS_EN
  logic [15:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (valid_reg && rsp_ready && state_reg == RESP) begin
      cnt_reg <= cnt_reg + 16'd1;
    end
  end

  assign served_cnt = cnt_reg;
`endif

endmodule

// File: tb/tb_logic_eval_arbiter.sv
// Scoreboard bench for logic_eval_arbiter: expected (id, z) pushed at request, popped at handshake.
module tb_logic_eval_arbiter;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N*W-1:0]  a_in = '0;
  logic [N*W-1:0]  b_in = '0;
  logic [N*W-1:0]  c_in = '0;
  logic            rsp_ready = 1'b0;
  logic [N-1:0]    gnt;
  logic            rsp_valid;
  logic [IW-1:0]   rsp_id;
  logic [W-1:0]    rsp_z;
  logic            busy;
`ifdef LOGIC_ARB_STATS_EN
  logic [15:0]     served_cnt;
`endif

  typedef struct packed {
    logic [IW-1:0] id;
    logic [W-1:0]  z;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;
  int exp_ptr = N - 1;
  int cyc = 0;
  int last_gnt = 0;
  int hs_count = 0;

  logic_eval_arbiter #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst), .req(req),
    .a_in(a_in), .b_in(b_in), .c_in(c_in),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_z(rsp_z),
    .rsp_ready(rsp_ready), .busy(busy)
`ifdef LOGIC_ARB_STATS_EN
    , .served_cnt(served_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r);
    for (int k = 1; k <= N; k++) begin
      if (r[(exp_ptr + k) % N]) return (exp_ptr + k) % N;
    end
    return 0;
  endfunction

  task automatic scramble();
    a_in = $urandom;
    b_in = $urandom;
    c_in = $urandom;
  endtask

  // Called just after a negedge; operands must already be driven.
  task automatic run_txn(input logic [N-1:0] r, input bit hold, input int delay, input bit gap_chk);
    int w;
    int t;
    exp_t e;
    logic [W-1:0] av, bv, cv, z0;
    w  = pick(r);
    av = a_in[w*W +: W];
    bv = b_in[w*W +: W];
    cv = c_in[w*W +: W];
    e.id = IW'(w);
    e.z  = (bv & cv) | (av & ~bv);
    sb.push_back(e);
    req = r;
    rsp_ready = (delay == 0);
    t = 0;
    while (t < 12) begin
      @(negedge clk);
      t++;
      if (gnt != '0) break;
    end
    check("gnt", 32'(gnt), 32'(1 << w));
    if (gap_chk) check("gnt_gap", 32'(cyc - last_gnt), 32'd3);
    last_gnt = cyc;
    check("busy_eval", 32'(busy), 32'd1);
    if (!hold) req = '0;
    scramble();
    @(negedge clk);
    check("gnt_drop", 32'(gnt), 32'd0);
    check("rsp_valid", 32'(rsp_valid), 32'd1);
    z0 = rsp_z;
    for (int d = 0; d < delay; d++) begin
      @(negedge clk);
      check("stall_valid", 32'(rsp_valid), 32'd1);
      check("stall_z", 32'(rsp_z), 32'(z0));
      check("stall_gnt", 32'(gnt), 32'd0);
    end
    rsp_ready = 1'b1;
    check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("rsp_id", 32'(rsp_id), 32'(e.id));
      check("rsp_z", 32'(rsp_z), 32'(e.z));
      exp_ptr = int'(e.id);
    end
    hs_count++;
    @(negedge clk);
    check("hs_valid", 32'(rsp_valid), 32'd0);
    check("hs_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    // Reset with all requests active.
    req = 4'b1111;
    scramble();
    repeat (2) @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;

    // Held requests: grants 0,1,2,3,0 three cycles apart.
    for (int i = 0; i < 5; i++) begin
      scramble();
      run_txn(4'b1111, 1'b1, 0, i != 0);
    end
    req = '0;
    @(negedge clk);

    // Directed operands on requester 0: z must be 8'hB8.
    scramble();
    a_in[0 +: W] = 8'hF0;
    b_in[0 +: W] = 8'hCC;
    c_in[0 +: W] = 8'hAA;
    run_txn(4'b0001, 1'b0, 0, 1'b0);

    // Back-pressure: five stalled cycles in RESP.
    scramble();
    run_txn(4'b1010, 1'b0, 5, 1'b0);
    for (int i = 0; i < 4; i++) begin
      scramble();
      run_txn(4'($urandom_range(1, 15)), 1'b0, i % 3, 1'b0);
    end

    // Reset in RESP for requester 2 drops the transaction.
    scramble();
    req = 4'b0100;
    rsp_ready = 1'b0;
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      if (gnt != '0) break;
    end
    check("rst5_gnt", 32'(gnt), 32'b0100);
    req = '0;
    @(negedge clk);
    check("rst5_valid_pre", 32'(rsp_valid), 32'd1);
    check("rst5_id_pre", 32'(rsp_id), 32'd2);
    rst = 1'b1;
    @(negedge clk);
    check("rst5_valid", 32'(rsp_valid), 32'd0);
    check("rst5_busy", 32'(busy), 32'd0);
    check("rst5_z", 32'(rsp_z), 32'd0);
    check("rst5_id", 32'(rsp_id), 32'd0);
    rst = 1'b0;
    exp_ptr = N - 1;
    sb.delete();
    hs_count = 0;
    scramble();
    run_txn(4'b1111, 1'b0, 0, 1'b0);

    for (int i = 0; i < 9; i++) begin
      scramble();
      run_txn(4'($urandom_range(1, 15)), 1'b0, 0, 1'b0);
    end
`ifdef LOGIC_ARB_STATS_EN
    check("served_cnt", 32'(served_cnt), 32'(hs_count));
    check("served_cnt_10", 32'(hs_count), 32'd10);
`endif
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
